// File: rtl/convmax_host_master.sv
// Avalon-MM master that streams one conv-max frame into the slave and reads back the result.
// Each frame is NUM_WORDS input words written to byte addresses 0,4,.. followed by one read at
// address 0. The read returns maxval in [15:0] and maxpos in [23:16], which are presented on a
// valid/ready result port.
module convmax_host_master #(
  parameter int unsigned NUM_WORDS = 38,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              res_valid,
  output logic [15:0]       res_maxval,
  output logic [7:0]        res_maxpos,
  input  logic              res_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned CntW = $clog2(NUM_WORDS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRd, StResult} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   acc_cnt_q, acc_cnt_d;    // words accepted from the input stream
  logic [CntW-1:0]   word_idx_q, word_idx_d;  // writes completed on the Avalon side
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       res_q, res_d;
  logic              err_q, err_d;
  logic              accept;
  logic              stalled;
  logic              tmo_hit;
  logic [7:0]        unused_readdata;

  assign unused_readdata = avm_readdata[31:24];

  // The write register doubles as a one-word holding buffer: a new word may enter in the same
  // cycle the pending write completes, so a zero-wait slave sees no bubbles.
  assign in_ready = (state_q == StLoad) && (acc_cnt_q < CntW'(NUM_WORDS)) &&
                    (!write_q || !avm_waitrequest);
  assign accept   = in_valid && in_ready;
  assign stalled  = (write_q || read_q) && avm_waitrequest;
  assign tmo_hit  = stalled && (tmo_cnt_q == TmoW'(TIMEOUT - 1));

  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = (write_q || read_q) ? 4'hF : 4'h0;
  assign res_valid      = (state_q == StResult);
  assign res_maxval     = res_q[15:0];
  assign res_maxpos     = res_q[23:16];
  assign busy           = (state_q != StIdle);
  assign err_timeout    = err_q;

  // Next-state, request and result-capture logic.
  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    word_idx_d = word_idx_q;
    tmo_cnt_d  = stalled ? tmo_cnt_q + TmoW'(1) : '0;
    write_d    = write_q;
    read_d     = read_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    res_d      = res_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          acc_cnt_d  = '0;
          word_idx_d = '0;
          err_d      = 1'b0;
        end
      end
      StLoad: begin
        if (write_q && !avm_waitrequest) begin
          write_d    = 1'b0;
          word_idx_d = word_idx_q + CntW'(1);
          if (word_idx_q == CntW'(NUM_WORDS - 1)) begin
            state_d = StRd;
            read_d  = 1'b1;
            addr_d  = '0;
          end
        end
        // A fresh accept overrides the completion drop above.
        if (accept) begin
          write_d   = 1'b1;
          addr_d    = ADDR_W'({acc_cnt_q, 2'b00});
          wdata_d   = in_data;
          acc_cnt_d = acc_cnt_q + CntW'(1);
        end
      end
      StRd: begin
        if (read_q && !avm_waitrequest) begin
          read_d  = 1'b0;
          res_d   = avm_readdata[23:0];
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort the frame when a single transfer has stalled for TIMEOUT cycles.
    if (tmo_hit) begin
      write_d = 1'b0;
      read_d  = 1'b0;
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  // State and datapath registers; reset drops Avalon requests immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      acc_cnt_q  <= '0;
      word_idx_q <= '0;
      tmo_cnt_q  <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      word_idx_q <= word_idx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      write_q    <= write_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      res_q      <= res_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_convmax_host_master.sv
// Directed bench for convmax_host_master: a stall-programmable Avalon slave model logs every
// transfer, and a linear sequence of frames checks data, ordering, timing, stalls, timeout,
// reset and ignored-input behaviour.
module tb_convmax_host_master;

  localparam int NW = 38;

  logic        clk;
  logic        reset_n;
  logic        start, in_valid, res_ready;
  logic [31:0] in_data;
  logic        in_ready, res_valid, busy, err_timeout;
  logic [15:0] res_maxval;
  logic [7:0]  res_maxpos;
  logic [10:0] avm_address;
  logic        avm_write, avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  // Second instance with a short timeout for the abort scenario.
  logic        t_start, t_in_valid, t_res_ready, t_stuck;
  logic        t_in_ready, t_res_valid, t_busy, t_err;
  logic [15:0] t_res_maxval;
  logic [7:0]  t_res_maxpos;
  logic [10:0] t_address;
  logic        t_write, t_read;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;
  logic        t_waitrequest;
  logic        t_resv_seen;

  assign t_waitrequest = t_read && t_stuck;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Slave-model state and transfer log.
  logic [31:0] rd_val;
  logic [10:0] wr_stall_addr;
  int          wr_stall, rd_stall, stall_left;
  bit          in_xfer;
  logic [10:0] h_addr;
  logic [31:0] h_data;
  logic        h_w;
  logic [10:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc [64];
  int          wr_cnt, rd_cnt, rd_cyc;
  logic [10:0] rd_addr;
  int          stab_err, rdy_err, both_err, be_err;
  int          acc0_cyc, resv_cyc;

  convmax_host_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_maxval(res_maxval),
    .res_maxpos(res_maxpos), .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  convmax_host_master #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .start(t_start), .in_valid(t_in_valid),
    .in_data(32'h0000_0011), .in_ready(t_in_ready), .res_valid(t_res_valid),
    .res_maxval(t_res_maxval), .res_maxpos(t_res_maxpos), .res_ready(t_res_ready),
    .busy(t_busy), .err_timeout(t_err), .avm_address(t_address), .avm_write(t_write),
    .avm_read(t_read), .avm_byteenable(t_be), .avm_writedata(t_wdata),
    .avm_readdata(32'h0011_2233), .avm_waitrequest(t_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decides waitrequest at each falling edge and logs completed transfers.
  always @(negedge clk) begin
    if (avm_write && avm_read) both_err++;
    if (avm_byteenable !== ((avm_write || avm_read) ? 4'hF : 4'h0)) be_err++;
    if (avm_waitrequest && avm_write && in_ready) rdy_err++;
    if (avm_write || avm_read) begin
      if (!in_xfer) begin
        in_xfer    = 1'b1;
        h_addr     = avm_address;
        h_data     = avm_writedata;
        h_w        = avm_write;
        stall_left = avm_read ? rd_stall : ((avm_address == wr_stall_addr) ? wr_stall : 0);
      end else if (avm_address !== h_addr || avm_writedata !== h_data || avm_write !== h_w) begin
        stab_err++;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hDEAD_BEEF;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_xfer         = 1'b0;
        avm_readdata    = avm_read ? rd_val : 32'hDEAD_BEEF;
        if (avm_write) begin
          if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = avm_address;
            wr_data[wr_cnt] = avm_writedata;
            wr_cyc[wr_cnt]  = cyc;
          end
          wr_cnt++;
        end else begin
          rd_cnt++;
          rd_cyc  = cyc;
          rd_addr = avm_address;
        end
      end
    end else begin
      in_xfer         = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'hDEAD_BEEF;
    end
    if (t_res_valid) t_resv_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] wexp(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic clear_logs();
    wr_cnt = 0; rd_cnt = 0; rd_addr = '1;
    stab_err = 0; rdy_err = 0; both_err = 0; be_err = 0;
  endtask

  task automatic check_frame(input string tn);
    chk({tn, "_wr_cnt"}, wr_cnt, NW);
    chk({tn, "_rd_cnt"}, rd_cnt, 1);
    chk({tn, "_rd_addr"}, rd_addr, 0);
    for (int i = 0; i < NW && i < wr_cnt; i++) begin
      chk({tn, "_wr_addr"}, wr_addr[i], 4 * i);
      chk({tn, "_wr_data"}, wr_data[i], wexp(i));
    end
    chk({tn, "_stable"}, stab_err, 0);
    chk({tn, "_ready_in_stall"}, rdy_err, 0);
    chk({tn, "_both_req"}, both_err, 0);
    chk({tn, "_byteenable"}, be_err, 0);
  endtask

  // Runs one frame: in_valid high one cycle in every `gap`, result held for `hold` cycles.
  task automatic run_frame(input int gap, input int hold, input bit poke, input string tn);
    int idx = 0;
    int k = 0;
    bit got = 0;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      in_valid = (idx < NW) && (k % gap == 0);
      in_data  = wexp(idx);
      k++;
      start = poke && (idx == 10);
      #4;
      if (res_valid) begin
        got = 1'b1;
        resv_cyc = cyc;
      end else begin
        if (in_valid && in_ready) begin
          if (idx == 0) acc0_cyc = cyc;
          idx++;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({tn, "_res_valid_seen"}, got, 1);
    if (got) begin
      chk({tn, "_res_maxval"}, res_maxval, rd_val[15:0]);
      chk({tn, "_res_maxpos"}, res_maxpos, rd_val[23:16]);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); start = poke && (h == 2); #4;
        chk({tn, "_res_valid_hold"}, res_valid, 1);
        chk({tn, "_res_maxval_hold"}, res_maxval, rd_val[15:0]);
      end
      res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0; start = 1'b0; #4;
      chk({tn, "_busy_after_ack"}, busy, 0);
      chk({tn, "_res_valid_after_ack"}, res_valid, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tn);
    chk({tn, "_avm_write"}, avm_write, 0);
    chk({tn, "_avm_read"}, avm_read, 0);
    chk({tn, "_avm_address"}, avm_address, 0);
    chk({tn, "_avm_byteenable"}, avm_byteenable, 0);
    chk({tn, "_avm_writedata"}, avm_writedata, 0);
    chk({tn, "_in_ready"}, in_ready, 0);
    chk({tn, "_busy"}, busy, 0);
    chk({tn, "_res_valid"}, res_valid, 0);
    chk({tn, "_res_maxval"}, res_maxval, 0);
    chk({tn, "_res_maxpos"}, res_maxpos, 0);
    chk({tn, "_err_timeout"}, err_timeout, 0);
  endtask

  // Watchdog: the directed sequence finishes far earlier than this.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit found;
    int idx;
    reset_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    t_start = 1'b0; t_in_valid = 1'b0; t_res_ready = 1'b0; t_stuck = 1'b0; t_resv_seen = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    rd_val = 32'h002A_1234; wr_stall_addr = 11'h7FF; wr_stall = 0; rd_stall = 0;
    stall_left = 0; in_xfer = 1'b0;
    clear_logs();

    // Reset state.
    #2;
    check_reset_outputs("reset");
    chk("reset_t_busy", t_busy, 0);
    @(negedge clk); reset_n = 1'b1;

    // 1: zero-wait slave, continuous input, back-to-back timing.
    run_frame(1, 0, 1'b0, "t1");
    check_frame("t1");
    if (wr_cnt == NW) begin
      chk("t1_first_write_lat", wr_cyc[0], acc0_cyc + 1);
      chk("t1_write_span", wr_cyc[NW-1] - wr_cyc[0], NW - 1);
      chk("t1_read_lat", rd_cyc, wr_cyc[NW-1] + 1);
      chk("t1_res_valid_lat", resv_cyc, rd_cyc + 1);
    end

    // 2: stall word 5 for 3 cycles and the read for 20 cycles.
    wr_stall_addr = 11'd20; wr_stall = 3; rd_stall = 20;
    run_frame(1, 0, 1'b0, "t2");
    check_frame("t2");
    wr_stall_addr = 11'h7FF; wr_stall = 0; rd_stall = 0;

    // 3: sparse input, result held unacknowledged for 10 cycles.
    rd_val = 32'hFF7F_BEEF;
    run_frame(3, 10, 1'b0, "t3");
    check_frame("t3");

    // 4: read stuck in waitrequest on the short-timeout instance.
    t_stuck = 1'b1; t_resv_seen = 1'b0;
    @(negedge clk); t_start = 1'b1;
    @(negedge clk); t_start = 1'b0; t_in_valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      #4;
      if (t_read) found = 1'b1;
      else @(negedge clk);
    end
    chk("t4_read_issued", found, 1);
    cnt = 0;
    while (t_read && cnt < 100) begin
      cnt++;
      @(negedge clk); #4;
    end
    chk("t4_stalled_read_cycles", cnt, 16);
    chk("t4_err_timeout", t_err, 1);
    chk("t4_busy_after_abort", t_busy, 0);
    chk("t4_in_ready_after_abort", t_in_ready, 0);
    repeat (5) @(negedge clk);
    chk("t4_no_result", t_resv_seen, 0);
    t_stuck = 1'b0;
    t_start = 1'b1;
    @(negedge clk); t_start = 1'b0; #4;
    chk("t4_err_cleared", t_err, 0);
    chk("t4_busy_restart", t_busy, 1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (t_res_valid) found = 1'b1;
      else begin
        @(negedge clk); #4;
      end
    end
    chk("t4_second_result", found, 1);
    chk("t4_second_maxval", t_res_maxval, 16'h2233);
    chk("t4_second_maxpos", t_res_maxpos, 8'h11);
    t_res_ready = 1'b1; t_in_valid = 1'b0;
    @(negedge clk); t_res_ready = 1'b0; #4;
    chk("t4_second_idle", t_busy, 0);

    // 5: reset asserted while word 12 is being written.
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0; idx = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (avm_write && avm_address == 11'd48) begin
        found = 1'b1;
      end else begin
        in_valid = (idx < NW); in_data = wexp(idx);
        #4;
        if (in_valid && in_ready) idx++;
        @(negedge clk);
      end
    end
    chk("t5_word12_reached", found, 1);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_midreset");
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    rd_val = 32'h0013_0077;
    run_frame(1, 0, 1'b0, "t5_after");
    check_frame("t5_after");

    // 6: in_valid while idle, start pulses during load and result.
    clear_logs();
    in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      chk("t6_idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_idle_no_xfer", wr_cnt + rd_cnt, 0);
    rd_val = 32'h0005_00A5;
    run_frame(1, 4, 1'b1, "t6");
    check_frame("t6");
    repeat (5) @(negedge clk);
    chk("t6_no_extra_writes", wr_cnt, NW);
    chk("t6_no_extra_reads", rd_cnt, 1);
    chk("t6_idle_at_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
